// File: rtl/dvp_pattern_gen.sv
// Synthetic OV7670-style DVP source: vsync/href/byte stream carrying
// RGB565 test patterns, high byte first, free-running while enabled.
module dvp_pattern_gen #(
    parameter int p_width        = 160,
    parameter int p_height       = 120,
    parameter int p_vsync_cycles = 64,
    parameter int p_vfront       = 32,
    parameter int p_hblank       = 16,
    parameter int p_vback        = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic [1:0] i_pattern,
    output logic       o_vsync,
    output logic       o_href,
    output logic [7:0] o_data,
    output logic       o_frame_done,
    output logic [7:0] o_frame_count
);

    localparam int CW = 18;
    localparam logic [CW-1:0] C_VS   = CW'(p_vsync_cycles - 1);
    localparam logic [CW-1:0] C_VF   = CW'(p_vfront - 1);
    localparam logic [CW-1:0] C_HB   = CW'(p_hblank - 1);
    localparam logic [CW-1:0] C_VB   = CW'(p_vback - 1);
    localparam logic [CW-1:0] C_LINE = CW'(2 * p_width - 1);
    localparam logic [15:0] C_YLAST  = 16'(p_height - 1);
    localparam logic [15:0] C_BLAST  = 16'(p_width / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VFRONT, S_LINE, S_HBLANK, S_VBACK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   x, x_nxt, y, y_nxt;
    logic [15:0]   addr, addr_nxt, bcnt, bcnt_nxt;
    logic [2:0]    bar, bar_nxt;
    logic          phase, phase_nxt;
    logic [1:0]    pat, pat_nxt;
    logic [5:0]    fc, fc_nxt;
    logic          last, done;
    logic [15:0]   pix;

    assign last = (cnt == '0);
    assign done = (state == S_VBACK) && last;

    // Counters describe the byte emitted on the following cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CW'(1);
        x_nxt     = x;
        y_nxt     = y;
        addr_nxt  = addr;
        bcnt_nxt  = bcnt;
        bar_nxt   = bar;
        phase_nxt = phase;
        pat_nxt   = pat;
        fc_nxt    = fc;
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (i_enable) begin
                    state_nxt = S_VSYNC;
                    cnt_nxt   = C_VS;
                    pat_nxt   = i_pattern;
                    fc_nxt    = o_frame_count[5:0];
                end
            end
            S_VSYNC: begin
                addr_nxt = '0;
                y_nxt    = '0;
                if (last) begin
                    state_nxt = S_VFRONT;
                    cnt_nxt   = C_VF;
                end
            end
            S_VFRONT, S_HBLANK: begin
                if (last) begin
                    state_nxt = S_LINE;
                    cnt_nxt   = C_LINE;
                end
            end
            S_LINE: begin
                phase_nxt = ~phase;
                if (phase) begin
                    x_nxt    = x + 16'd1;
                    addr_nxt = addr + 16'd1;
                    if (bcnt == C_BLAST) begin
                        bcnt_nxt = '0;
                        bar_nxt  = bar + 3'd1;
                    end else begin
                        bcnt_nxt = bcnt + 16'd1;
                    end
                end
                if (last) begin
                    x_nxt     = '0;
                    bcnt_nxt  = '0;
                    bar_nxt   = '0;
                    phase_nxt = 1'b0;
                    if (y == C_YLAST) begin
                        state_nxt = S_VBACK;
                        cnt_nxt   = C_VB;
                    end else begin
                        state_nxt = S_HBLANK;
                        cnt_nxt   = C_HB;
                        y_nxt     = y + 16'd1;
                    end
                end
            end
            S_VBACK: begin
                if (last) begin
                    if (i_enable) begin
                        state_nxt = S_VSYNC;
                        cnt_nxt   = C_VS;
                        pat_nxt   = i_pattern;
                        fc_nxt    = o_frame_count[5:0] + 6'd1;
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        pix = '0;
        unique case (pat)
            2'd0: pix = addr;
            2'd1: begin
                unique case (bar)
                    3'd0: pix = 16'hFFFF;
                    3'd1: pix = 16'hFFE0;
                    3'd2: pix = 16'h07FF;
                    3'd3: pix = 16'h07E0;
                    3'd4: pix = 16'hF81F;
                    3'd5: pix = 16'hF800;
                    3'd6: pix = 16'h001F;
                    3'd7: pix = 16'h0000;
                endcase
            end
            2'd2: pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            2'd3: pix = {fc[4:0], fc, fc[4:0]};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            bcnt  <= '0;
            bar   <= '0;
            phase <= 1'b0;
            pat   <= '0;
            fc    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            addr  <= addr_nxt;
            bcnt  <= bcnt_nxt;
            bar   <= bar_nxt;
            phase <= phase_nxt;
            pat   <= pat_nxt;
            fc    <= fc_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vsync       <= 1'b0;
            o_href        <= 1'b0;
            o_data        <= '0;
            o_frame_done  <= 1'b0;
            o_frame_count <= '0;
        end else begin
            o_vsync       <= (state == S_VSYNC);
            o_href        <= (state == S_LINE);
            o_data        <= (state != S_LINE) ? 8'h00 :
                             phase ? pix[7:0] : pix[15:8];
            o_frame_done  <= done;
            o_frame_count <= o_frame_count + {7'd0, done};
        end
    end

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Bench for dvp_pattern_gen: byte scoreboard fed by a pattern model,
// plus framing, timing, enable and reset checks.
module tb_dvp_pattern_gen;

    localparam int W  = 32;
    localparam int H  = 12;
    localparam int VS = 6;
    localparam int VF = 5;
    localparam int HB = 3;
    localparam int VB = 4;
    localparam int PERIOD = VS + VF + H * 2 * W + (H - 1) * HB + VB;
    localparam logic [15:0] BARS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] pat;
    logic       vs, href, done;
    logic [7:0] data, fcnt;

    always #5 clk = ~clk;

    dvp_pattern_gen #(
        .p_width(W), .p_height(H), .p_vsync_cycles(VS),
        .p_vfront(VF), .p_hblank(HB), .p_vback(VB)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_pattern(pat),
        .o_vsync(vs), .o_href(href), .o_data(data),
        .o_frame_done(done), .o_frame_count(fcnt)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sb [$];
    int exp_fc = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int p, input int fc);
        logic [15:0] px;
        logic [7:0]  f;
        f = 8'(fc);
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                case (p)
                    0: px = 16'(yy * W + xx);
                    1: px = BARS[xx / (W / 8)];
                    2: px = (((xx / 8) % 2) != ((yy / 8) % 2)) ?
                            16'hFFFF : 16'h0000;
                    default: px = {f[4:0], f[5:0], f[4:0]};
                endcase
                sb.push_back(px[15:8]);
                sb.push_back(px[7:0]);
            end
        end
    endtask

    function automatic int mid(input int k);
        return VS + VF + k * (2 * W + HB) + W;
    endfunction

    task automatic wait_done(input string tag);
        int  i;
        logic seen;
        i = 0;
        seen = 1'b0;
        while (!seen && i < 2 * PERIOD) begin
            @(negedge clk);
            seen = done;
            i++;
        end
        check({tag, "_timeout"}, 32'(seen), 1);
    endtask

    task automatic wait_vs(input string tag);
        int  i;
        logic seen;
        i = 0;
        seen = 1'b0;
        while (!seen && i < 50) begin
            @(negedge clk);
            seen = vs;
            i++;
        end
        check({tag, "_timeout"}, 32'(seen), 1);
    endtask

    // Monitor: framing/timing checks and scoreboard pops
    logic       pv_vs = 1'b0;
    logic       pv_hr = 1'b0;
    logic [7:0] e;
    int cyc = 0, lines = 0, hrun = 0, lrun = 0, vsrun = 0;

    always @(negedge clk) begin
        if (rst) begin
            pv_vs = 1'b0;
            pv_hr = 1'b0;
            lines = 0;
            hrun = 0;
            lrun = 0;
            vsrun = 0;
            exp_fc = 0;
        end else begin
            check("vs_href_excl", 32'(vs & href), 0);
            if (vs && !pv_vs) begin
                cyc = 0;
                lines = 0;
                vsrun = 0;
            end else begin
                cyc++;
            end
            if (vs) vsrun++;
            else if (pv_vs) check("vs_len", vsrun, VS);
            if (href) begin
                if (!pv_hr) begin
                    if (lines == 0) check("href_delay", cyc, VS + VF);
                    else check("hblank_len", lrun, HB);
                    lines++;
                    hrun = 0;
                end
                hrun++;
                if (sb.size() == 0) begin
                    check("sb_underrun", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("byte", {24'd0, data}, {24'd0, e});
                end
            end else begin
                check("data_idle", {24'd0, data}, 0);
                if (pv_hr) begin
                    check("line_len", hrun, 2 * W);
                    lrun = 0;
                end
                lrun++;
            end
            if (done) begin
                exp_fc = (exp_fc + 1) % 256;
                check("frame_len", cyc, PERIOD - 1);
                check("lines", lines, H);
                check("fcount", {24'd0, fcnt}, exp_fc);
            end
            pv_vs = vs;
            pv_hr = href;
        end
    end

    initial begin
        #(10 * 50000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nz;
        rst = 1'b1;
        en  = 1'b0;
        pat = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_vsync", 32'(vs), 0);
        check("rst_href", 32'(href), 0);
        check("rst_data", {24'd0, data}, 0);
        check("rst_done", 32'(done), 0);
        check("rst_fcount", {24'd0, fcnt}, 0);
        rst = 1'b0;

        nz = 0;
        repeat (100) begin
            @(negedge clk);
            if (vs | href | done | (data != 0) | (fcnt != 0)) nz = 1;
        end
        check("idle_quiet", nz, 0);

        // Frame A pattern 0; pattern changed mid-frame goes to B
        push_frame(0, 0);
        en = 1'b1;
        @(negedge clk);
        check("vs_edge_n", 32'(vs), 0);
        @(negedge clk);
        check("vs_edge_n1", 32'(vs), 1);
        repeat (mid(5)) @(negedge clk);
        pat = 2'd1;
        push_frame(1, 1);
        wait_done("frame_a");

        repeat (1 + mid(5)) @(negedge clk);
        pat = 2'd2;
        push_frame(2, 2);
        wait_done("frame_b");

        repeat (1 + mid(5)) @(negedge clk);
        pat = 2'd3;
        push_frame(3, 3);
        wait_done("frame_c");

        // Drop enable mid-line in frame D: D completes, then idle
        repeat (1 + mid(6)) @(negedge clk);
        en  = 1'b0;
        pat = 2'd1;
        wait_done("frame_d");
        nz = 0;
        repeat (50) begin
            @(negedge clk);
            if (vs | href) nz = 1;
        end
        check("idle_after_drop", nz, 0);
        check("fcount_after_d", {24'd0, fcnt}, 4);
        check("sb_drained", sb.size(), 0);

        // Reset pulsed mid-line, then a clean restart from address 0
        pat = 2'd0;
        push_frame(0, 4);
        en = 1'b1;
        wait_vs("vs_frame_e");
        repeat (mid(3)) @(negedge clk);
        check("mid_line_href", 32'(href), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_vsync", 32'(vs), 0);
        check("mrst_href", 32'(href), 0);
        check("mrst_data", {24'd0, data}, 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_fcount", {24'd0, fcnt}, 0);
        sb.delete();
        push_frame(0, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_vs("vs_restart");
        repeat (mid(4)) @(negedge clk);
        en = 1'b0;
        wait_done("frame_f");
        repeat (20) @(negedge clk);
        check("sb_final", sb.size(), 0);
        check("fcount_final", {24'd0, fcnt}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
